// File: rtl/mem_bus2_pkg.sv
// rtl/mem_bus2_pkg.sv - shared bus2 codes, state encoding and default sizes
package mem_bus2_pkg;

    localparam int ADDR2_W_DEF     = 15;
    localparam int DATA2_W_DEF     = 16;
    localparam int CTR2_W_DEF      = 2;
    localparam int LINE_BEATS_DEF  = 8;
    localparam int TIMEOUT_DEF     = 255;
    localparam int BEAT_W_DEF      = $clog2(LINE_BEATS_DEF);

    localparam logic [CTR2_W_DEF-1:0] C2_NOP        = 2'd0;
    localparam logic [CTR2_W_DEF-1:0] C2_RESPONSE   = 2'd1;
    localparam logic [CTR2_W_DEF-1:0] C2_READ_LINE  = 2'd2;
    localparam logic [CTR2_W_DEF-1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WBURST,
        S_TURN,
        S_WAIT_RESP,
        S_RBURST,
        S_RELEASE
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin winner select with LAST owner register
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       last_we,
    input  logic       last_in,
    output logic       any_req,
    output logic       winner
);

    logic last_q;
    logic last_d;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        any_req = |req;
        winner  = req[1];
        if (req == 2'b11) begin
            winner = ~last_q;
        end
        last_d = last_we ? last_in : last_q;
    end

    // LAST comes out of reset pointing at R1 so R0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_bus2_arbiter.sv
// rtl/mem_bus2_arbiter.sv - bus2 master: arbitrates two caches and sequences line transfers
module mem_bus2_arbiter
    import mem_bus2_pkg::*;
#(
    parameter int ADDR2_BUS_SIZE = ADDR2_W_DEF,
    parameter int DATA2_BUS_SIZE = DATA2_W_DEF,
    parameter int CTR2_BUS_SIZE  = CTR2_W_DEF,
    parameter int LINE_BEATS     = LINE_BEATS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    inout  wire  [ADDR2_BUS_SIZE-1:0]     A2_WIRE,
    inout  wire  [DATA2_BUS_SIZE-1:0]     D2_WIRE,
    inout  wire  [CTR2_BUS_SIZE-1:0]      C2_WIRE,
    input  logic [1:0]                    R_REQ,
    input  logic [CTR2_BUS_SIZE-1:0]      R0_CMD,
    input  logic [CTR2_BUS_SIZE-1:0]      R1_CMD,
    input  logic [ADDR2_BUS_SIZE-1:0]     R0_ADDR,
    input  logic [ADDR2_BUS_SIZE-1:0]     R1_ADDR,
    input  logic [DATA2_BUS_SIZE-1:0]     R0_WDATA,
    input  logic [DATA2_BUS_SIZE-1:0]     R1_WDATA,
    output logic [1:0]                    R_GNT,
    output logic [$clog2(LINE_BEATS)-1:0] BEAT,
    output logic [DATA2_BUS_SIZE-1:0]     RDATA,
    output logic [1:0]                    R_RVALID,
    output logic [1:0]                    R_DONE,
    output logic [1:0]                    R_ERR
);

    localparam int BW = $clog2(LINE_BEATS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] RD_LAST_BEAT = BW'(LINE_BEATS - 2);
    localparam logic [TW-1:0] TCNT_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR2_BUS_SIZE-1:0] NOP  = CTR2_BUS_SIZE'(C2_NOP);
    localparam logic [CTR2_BUS_SIZE-1:0] RESP = CTR2_BUS_SIZE'(C2_RESPONSE);
    localparam logic [CTR2_BUS_SIZE-1:0] WR   = CTR2_BUS_SIZE'(C2_WRITE_LINE);

    state_t                      state_q, state_d;
    logic                        owner_q, owner_d;
    logic [1:0]                  gnt_q, gnt_d;
    logic [CTR2_BUS_SIZE-1:0]    cmd_q, cmd_d;
    logic [ADDR2_BUS_SIZE-1:0]   addr_q, addr_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [DATA2_BUS_SIZE-1:0]   rdata_q, rdata_d;
    logic [1:0]                  rvalid_q, rvalid_d;
    logic [1:0]                  done_q, done_d;
    logic [1:0]                  err_q, err_d;
    logic [TW-1:0]               tcnt_q, tcnt_d;
    logic                        c2_oe_q, c2_oe_d;
    logic                        a2_oe_q, a2_oe_d;
    logic                        d2_oe_q, d2_oe_d;
    logic                        any_req;
    logic                        winner;

    rr_arbiter2 u_rr (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .req     (R_REQ),
        .last_we (state_q == S_RELEASE),
        .last_in (owner_q),
        .any_req (any_req),
        .winner  (winner)
    );

    // Drive enables are registered from the next state so reset releases every line at once.
    assign C2_WIRE = c2_oe_q ? ((state_q == S_IDLE) ? NOP : cmd_q) : 'z;
    assign A2_WIRE = a2_oe_q ? addr_q : 'z;
    assign D2_WIRE = d2_oe_q ? (owner_q ? R1_WDATA : R0_WDATA) : 'z;

    assign R_GNT    = gnt_q;
    assign BEAT     = beat_q;
    assign RDATA    = rdata_q;
    assign R_RVALID = rvalid_q;
    assign R_DONE   = done_q;
    assign R_ERR    = err_q;

    // Transaction sequencer: next state, beat counter, capture and completion pulses.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        done_d   = 2'b00;
        err_d    = 2'b00;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (any_req) begin
                    owner_d = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    cmd_d   = winner ? R1_CMD : R0_CMD;
                    addr_d  = winner ? R1_ADDR : R0_ADDR;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_q == WR) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = S_WBURST;
                end else begin
                    state_d = S_TURN;
                end
            end
            S_WBURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(LINE_BEATS - 1)) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                tcnt_d  = '0;
                state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (C2_WIRE == RESP) begin
                    if (cmd_q == WR) begin
                        done_d  = gnt_q;
                        state_d = S_RELEASE;
                    end else begin
                        rdata_d  = D2_WIRE;
                        rvalid_d = gnt_q;
                        beat_d   = '0;
                        state_d  = S_RBURST;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    err_d   = gnt_q;
                    state_d = S_RELEASE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RBURST: begin
                if (C2_WIRE == RESP) begin
                    rdata_d  = D2_WIRE;
                    rvalid_d = gnt_q;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == RD_LAST_BEAT) begin
                        done_d  = gnt_q;
                        state_d = S_RELEASE;
                    end
                end else begin
                    err_d   = gnt_q;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                gnt_d   = 2'b00;
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        c2_oe_d = (state_d == S_IDLE) || (state_d == S_CMD) || (state_d == S_WBURST);
        a2_oe_d = (state_d == S_CMD) || (state_d == S_WBURST);
        d2_oe_d = a2_oe_d && (cmd_d == WR);
    end

    // State and output registers; async reset leaves the bus floating and outputs low.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            cmd_q    <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            tcnt_q   <= '0;
            c2_oe_q  <= 1'b0;
            a2_oe_q  <= 1'b0;
            d2_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
            c2_oe_q  <= c2_oe_d;
            a2_oe_q  <= a2_oe_d;
            d2_oe_q  <= d2_oe_d;
        end
    end

endmodule

// File: tb/tb_mem_bus2_arbiter.sv
// tb/tb_mem_bus2_arbiter.sv - directed self-checking bench for mem_bus2_arbiter
module tb_mem_bus2_arbiter;

    localparam int TO = 255;
    localparam logic [1:0] RD = 2'd2;
    localparam logic [1:0] WR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    wire  [14:0] a2;
    wire  [15:0] d2;
    wire  [1:0]  c2;
    logic [1:0]  r_req;
    logic [1:0]  r0_cmd, r1_cmd;
    logic [14:0] r0_addr, r1_addr;
    logic [15:0] wbase0, wbase1;
    logic [15:0] r0_wdata, r1_wdata;
    logic [1:0]  r_gnt;
    logic [2:0]  beat;
    logic [15:0] rdata;
    logic [1:0]  r_rvalid, r_done, r_err;

    logic        m_c2_en, m_d2_en;
    logic [1:0]  m_c2;
    logic [15:0] m_d2;

    int n_checks = 0;
    int n_pass   = 0;

    // Floating lines read back as all ones.
    pullup (a2);
    pullup (d2);
    pullup (c2);

    assign c2 = m_c2_en ? m_c2 : 2'bzz;
    assign d2 = m_d2_en ? m_d2 : 16'hzzzz;

    assign r0_wdata = wbase0 + {13'd0, beat};
    assign r1_wdata = wbase1 + {13'd0, beat};

    always #5 clk = ~clk;

    mem_bus2_arbiter dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .A2_WIRE  (a2),
        .D2_WIRE  (d2),
        .C2_WIRE  (c2),
        .R_REQ    (r_req),
        .R0_CMD   (r0_cmd),
        .R1_CMD   (r1_cmd),
        .R0_ADDR  (r0_addr),
        .R1_ADDR  (r1_addr),
        .R0_WDATA (r0_wdata),
        .R1_WDATA (r1_wdata),
        .R_GNT    (r_gnt),
        .BEAT     (beat),
        .RDATA    (rdata),
        .R_RVALID (r_rvalid),
        .R_DONE   (r_done),
        .R_ERR    (r_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with the request already visible; ends in the RELEASE cycle.
    task automatic run_txn(input int own, input logic [1:0] cmd, input logic [14:0] addr,
                           input logic [15:0] base, input int delay, input bit respond);
        logic [1:0] oh;
        oh = (own == 1) ? 2'b10 : 2'b01;
        tick;
        check("cmd_gnt", r_gnt, oh);
        check("cmd_c2", c2, cmd);
        check("cmd_a2", a2, addr);
        check("cmd_beat", beat, 0);
        if (cmd == WR) begin
            check("cmd_d2", d2, base);
            for (int k = 1; k < 8; k++) begin
                tick;
                check("wb_d2", d2, base + k);
                check("wb_beat", beat, k);
                check("wb_a2", a2, addr);
            end
        end
        tick;
        check("turn_c2z", c2, 2'b11);
        check("turn_d2z", d2, 16'hFFFF);
        check("turn_gnt", r_gnt, oh);
        tick;
        if (!respond) begin
            repeat (TO - 1) tick;
            check("wait_no_err", r_err, 0);
            tick;
            check("to_err", r_err, oh);
            check("to_done", r_done, 0);
            check("to_c2z", c2, 2'b11);
        end else begin
            repeat (delay) tick;
            check("wait_rvalid", r_rvalid, 0);
            check("pre_resp_c2z", c2, 2'b11);
            m_c2    = 2'd1;
            m_c2_en = 1'b1;
            if (cmd == WR) begin
                tick;
                check("wr_done", r_done, oh);
                check("wr_rvalid", r_rvalid, 0);
            end else begin
                m_d2_en = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    m_d2 = base + 16'(k);
                    tick;
                    check("rd_rvalid", r_rvalid, oh);
                    check("rd_rdata", rdata, base + k);
                    check("rd_beat", beat, k);
                    check("rd_done", r_done, (k == 7) ? oh : 2'b00);
                end
            end
            m_c2_en = 1'b0;
            m_d2_en = 1'b0;
            #1;
            check("rel_c2z", c2, 2'b11);
            check("rel_d2z", d2, 16'hFFFF);
        end
        check("rel_gnt", r_gnt, oh);
        r_req[own] = 1'b0;
    endtask

    task automatic idle_check;
        tick;
        check("idle_gnt", r_gnt, 0);
        check("idle_c2_nop", c2, 0);
        check("idle_beat", beat, 0);
        check("idle_done", r_done, 0);
        check("idle_err", r_err, 0);
        check("idle_rvalid", r_rvalid, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        r_req   = 2'b00;
        r0_cmd  = 2'd0;
        r1_cmd  = 2'd0;
        r0_addr = '0;
        r1_addr = '0;
        wbase0  = '0;
        wbase1  = '0;
        m_c2_en = 1'b0;
        m_d2_en = 1'b0;
        m_c2    = 2'd0;
        m_d2    = '0;

        #3;
        check("rst_gnt", r_gnt, 0);
        check("rst_beat", beat, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", r_rvalid, 0);
        check("rst_done", r_done, 0);
        check("rst_err", r_err, 0);
        check("rst_c2z", c2, 2'b11);
        check("rst_a2z", a2, 15'h7FFF);
        check("rst_d2z", d2, 16'hFFFF);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check("post_rst_c2_nop", c2, 0);
        check("post_rst_a2z", a2, 15'h7FFF);

        // R0 line read, slow memory
        r0_cmd = RD; r0_addr = 15'h0012; r_req = 2'b01;
        run_txn(0, RD, 15'h0012, 16'h1000, 100, 1'b1);
        idle_check();

        // R1 line write to the top address
        r1_cmd = WR; r1_addr = 15'h7FFF; wbase1 = 16'h00A0; r_req = 2'b10;
        run_txn(1, WR, 15'h7FFF, 16'h00A0, 2, 1'b1);
        idle_check();

        // Memory never answers, then a normal request
        r0_cmd = RD; r0_addr = 15'h0100; r_req = 2'b01;
        run_txn(0, RD, 15'h0100, 16'h0000, 0, 1'b0);
        idle_check();
        r1_cmd = RD; r1_addr = 15'h0200; r_req = 2'b10;
        run_txn(1, RD, 15'h0200, 16'h2000, 3, 1'b1);
        idle_check();

        // Reset asserted during read beat 3
        r0_cmd = RD; r0_addr = 15'h0300; r_req = 2'b01;
        tick;
        check("rb_gnt", r_gnt, 2'b01);
        tick;
        tick;
        m_c2 = 2'd1; m_c2_en = 1'b1; m_d2_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_d2 = 16'h3000 + 16'(k);
            tick;
            check("rb_rdata", rdata, 16'h3000 + k);
        end
        check("rb_beat3", beat, 3);
        #2;
        rst_n = 1'b0; m_c2_en = 1'b0; m_d2_en = 1'b0; r_req = 2'b00;
        #1;
        check("arst_gnt", r_gnt, 0);
        check("arst_beat", beat, 0);
        check("arst_rdata", rdata, 0);
        check("arst_rvalid", r_rvalid, 0);
        check("arst_done", r_done, 0);
        check("arst_c2z", c2, 2'b11);
        check("arst_a2z", a2, 15'h7FFF);
        check("arst_d2z", d2, 16'hFFFF);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check("rerst_c2_nop", c2, 0);
        check("rerst_rvalid", r_rvalid, 0);
        repeat (3) tick;
        check("rerst_no_resume", r_rvalid, 0);
        check("rerst_gnt", r_gnt, 0);

        // Simultaneous requests after reset, then R0 re-raises right after its completion
        r0_cmd = RD; r0_addr = 15'h0400;
        r1_cmd = WR; r1_addr = 15'h0500; wbase1 = 16'h0050;
        r_req = 2'b11;
        run_txn(0, RD, 15'h0400, 16'h4000, 1, 1'b1);
        idle_check();
        r_req[0] = 1'b1;
        run_txn(1, WR, 15'h0500, 16'h0050, 1, 1'b1);
        idle_check();
        run_txn(0, RD, 15'h0400, 16'h4100, 0, 1'b1);
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus2_arbiter.md
Name: mem_bus2_arbiter

Overview:
- Shares the single bus2 (A2/D2/C2) between two cache-side requesters (R0 = instruction cache, R1 = data cache) and the memory controller.
- Owns bus2 on the master side and sequences one whole line transaction at a time: command, write burst, turnaround, response wait, read burst and release.
- Uses round-robin arbitration, with a response timeout to prevent lock-up.

Parameters:
- ADDR2_BUS_SIZE, 15, line-address width on A2.
- DATA2_BUS_SIZE, 16, D2 width (one beat).
- CTR2_BUS_SIZE, 2, C2 width.
- LINE_BEATS, 8, beats per cache line; must be ≥2 and a power of 2.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RESP before abort.

Ports:
- CLK  in  1  clock; all sampling on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- A2_WIRE  inout  ADDR2_BUS_SIZE  bus2 address.
- D2_WIRE  inout  DATA2_BUS_SIZE  bus2 data.
- C2_WIRE  inout  CTR2_BUS_SIZE  bus2 command.
- R_REQ  in  2  request per requester; held until the matching R_DONE.
- R0_CMD, R1_CMD  in  CTR2_BUS_SIZE  C2_READ_LINE or C2_WRITE_LINE; stable while R_REQ is high.
- R0_ADDR, R1_ADDR  in  ADDR2_BUS_SIZE  line address; stable while R_REQ is high.
- R0_WDATA, R1_WDATA  in  DATA2_BUS_SIZE  write beat selected by BEAT; combinational from the requester.
- R_GNT  out  2  one-hot owner; high from CMD through RELEASE.
- BEAT  out  log2(LINE_BEATS)  current beat index.
- RDATA  out  DATA2_BUS_SIZE  registered read beat.
- R_RVALID  out  2  one-cycle pulse per read beat, to the owner only.
- R_DONE  out  2  one-cycle completion pulse.
- R_ERR  out  2  one-cycle pulse in place of R_DONE when the timeout fires.

Behaviour:
- Reset (async, RESET_N=0):
  - R_GNT, BEAT, RDATA, R_RVALID, R_DONE and R_ERR are all 0.
  - All bus2 drivers are high-Z; state is IDLE.
  - LAST=1, so R0 wins the first tie.
  - After deassertion, C2 is driven to C2_NOP from the first posedge.
- C2 codes: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- IDLE:
  - Arbiter drives C2_NOP; A2/D2 are high-Z.
  - If any R_REQ is high, the winner is the requester ≠ LAST when both request, else the single requester.
  - Next state is CMD.
- CMD (1 cycle):
  - Drives C2=cmd and A2=addr.
  - For a write, also drives D2=WDATA with BEAT=0.
  - Write → WBURST; read → TURN.
- WBURST:
  - Drives D2 with BEAT=1..LINE_BEATS-1, one beat per cycle; C2 and A2 are held.
  - After the last beat → TURN.
- TURN (1 cycle): releases C2, A2 and D2 to high-Z; timeout counter cleared.
- WAIT_RESP:
  - Samples C2 each posedge.
  - On C2_RESPONSE:
    - Read: capture D2 as beat 0, RDATA=D2, R_RVALID pulse, BEAT=0 → RBURST (if LINE_BEATS>1).
    - Write: → RELEASE.
  - If the counter reaches TIMEOUT_CYCLES: → RELEASE with the error flag set.
- RBURST:
  - Captures beats 1..LINE_BEATS-1 on consecutive posedges, with one R_RVALID pulse each.
  - The memory controller holds C2_RESPONSE for the whole burst; a non-RESPONSE beat mid-burst is aborted as a timeout (error flag).
  - After the last beat → RELEASE.
- RELEASE (1 cycle):
  - Bus stays high-Z for one turnaround cycle; R_DONE or R_ERR pulses for the owner.
  - LAST=owner; R_GNT cleared; → IDLE, which drives C2_NOP.
- Back-to-back: a requester re-raising R_REQ in the cycle after R_DONE loses to a pending other requester. There is no starvation: at most one foreign transaction precedes any grant.
- A requester dropping R_REQ mid-transaction is ignored; the transaction completes.
- BEAT wraps naturally at LINE_BEATS; it is not advanced outside bursts and holds 0 in IDLE.
- The arbiter never drives a bus2 line while in TURN, WAIT_RESP, RBURST or RELEASE.

Decomposition:
- Package mem_bus2_pkg holds:
  - C2 command codes;
  - a state enum (IDLE, CMD, WBURST, TURN, WAIT_RESP, RBURST, RELEASE);
  - bus size localparams and the log2 beat width.
- Sub-module rr_arbiter2: combinational winner from R_REQ and LAST, plus the LAST register updated on a pulse input.

Test Plan:
- Reset then R0 read at 0x0012; the memory model responds after 100 cycles with beats 0x1000..0x1007 → bus shows:
  - C2=2 and A2=0x0012 for 1 cycle, then high-Z;
  - eight R_RVALID[0] pulses with RDATA 0x1000..0x1007;
  - R_DONE[0] one cycle after the last beat.
- R1 write at 0x7FFF with beats 0xA0..0xA7 → C2=3 for 8 cycles, D2=0xA0..0xA7, A2=0x7FFF; after the single-cycle response, R_DONE[1].
- R0 and R1 both raised in the same cycle after reset → R0 served first, then R1. Both raised again → R1 first, then R0 (alternation).
- Memory model never responds → R_ERR[0] exactly TIMEOUT_CYCLES cycles after TURN; bus high-Z; next request is served normally.
- RESET_N pulled low during RBURST beat 3 → all outputs 0 and bus high-Z immediately (same cycle, async). After release, C2=NOP, and R_RVALID does not resume.
- Bus contention check throughout all tests → no cycle where both the arbiter and the memory model drive non-Z on C2.
